// File: rtl/wshb_rr_arbiter.sv
// ----------------------------------------------------------------------------
// wshb_rr_arbiter : round-robin Wishbone arbiter sharing one SDRAM slave port.
// Optional macro WSHB_ARB_PRIO0_EN gives master 0 absolute priority.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module wshb_rr_arbiter #(
  parameter int NB_MASTERS = 2,
  parameter int ADR_W      = 32,
  parameter int DATA_W     = 16,
  parameter int MAX_ACKS   = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NB_MASTERS-1:0]          m_cyc,
  input  logic [NB_MASTERS-1:0]          m_stb,
  input  logic [NB_MASTERS-1:0]          m_we,
  input  logic [NB_MASTERS*ADR_W-1:0]    m_adr,
  input  logic [NB_MASTERS*DATA_W-1:0]   m_dat_ms,
  input  logic [NB_MASTERS*DATA_W/8-1:0] m_sel,
  input  logic [NB_MASTERS*3-1:0]        m_cti,
  input  logic [NB_MASTERS*2-1:0]        m_bte,
  output logic [NB_MASTERS-1:0]          m_ack,
  output logic [DATA_W-1:0]              m_dat_sm,
  output logic                           s_cyc,
  output logic                           s_stb,
  output logic                           s_we,
  output logic [ADR_W-1:0]               s_adr,
  output logic [DATA_W-1:0]              s_dat_ms,
  output logic [DATA_W/8-1:0]            s_sel,
  output logic [2:0]                     s_cti,
  output logic [1:0]                     s_bte,
  input  logic                           s_ack,
  input  logic [DATA_W-1:0]              s_dat_sm,
  output logic [NB_MASTERS-1:0]          grant
);

  localparam int                IDX_W       = (NB_MASTERS > 1) ? $clog2(NB_MASTERS) : 1;
  localparam int                SEL_W       = DATA_W / 8;
  localparam logic [15:0]       CNT_SAT     = 16'(MAX_ACKS);
  localparam logic [15:0]       LAST_BUDGET = 16'(MAX_ACKS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(NB_MASTERS - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t                  state, state_nx;
  logic [NB_MASTERS-1:0]   grant_nx;
  logic [IDX_W-1:0]        owner, owner_nx, pick;
  logic [15:0]             ack_cnt, ack_cnt_nx;
  logic                    found;
  int                      idx;
  logic                    own_cyc;
  logic [2:0]              own_cti;
  logic                    boundary, others_req, release_bus;

  assign m_dat_sm   = s_dat_sm;
  assign own_cyc    = m_cyc[owner];
  assign own_cti    = m_cti[int'(owner)*3 +: 3];
  assign boundary   = s_ack && (own_cti == 3'b000 || own_cti == 3'b111);
  assign others_req = |(m_cyc & ~grant);

  // Round-robin scan starts just after the previous owner.
  always_comb begin
    pick  = owner;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= NB_MASTERS; i++) begin
      idx = (int'(owner) + i) % NB_MASTERS;
      if (!found && m_cyc[idx]) begin
        pick  = IDX_W'(idx);
        found = 1'b1;
      end
    end
`ifdef WSHB_ARB_PRIO0_EN
    if (m_cyc[0]) pick = '0;
`endif
  end

  // Budget counts the current ack, so release lands right on the MAX_ACKS-th ack.
`ifdef WSHB_ARB_PRIO0_EN
  assign release_bus = !own_cyc ||
                       ((owner != '0) && boundary &&
                        (((ack_cnt >= LAST_BUDGET) && others_req) || m_cyc[0]));
`else
  assign release_bus = !own_cyc ||
                       ((ack_cnt >= LAST_BUDGET) && others_req && boundary);
`endif

  always_comb begin
    state_nx   = state;
    grant_nx   = grant;
    owner_nx   = owner;
    ack_cnt_nx = ack_cnt;
    m_ack      = '0;
    s_cyc      = 1'b0;
    s_stb      = 1'b0;
    s_we       = 1'b0;
    s_adr      = '0;
    s_dat_ms   = '0;
    s_sel      = '0;
    s_cti      = '0;
    s_bte      = '0;
    case (state)
      IDLE: begin
        if (|m_cyc) begin
          state_nx        = GRANT;
          grant_nx        = '0;
          grant_nx[pick]  = 1'b1;
          owner_nx        = pick;
          ack_cnt_nx      = '0;
        end
      end
      GRANT: begin
        s_cyc          = own_cyc;
        s_stb          = m_stb[owner];
        s_we           = m_we[owner];
        s_adr          = m_adr[int'(owner)*ADR_W +: ADR_W];
        s_dat_ms       = m_dat_ms[int'(owner)*DATA_W +: DATA_W];
        s_sel          = m_sel[int'(owner)*SEL_W +: SEL_W];
        s_cti          = own_cti;
        s_bte          = m_bte[int'(owner)*2 +: 2];
        m_ack[owner]   = s_ack && own_cyc;
        if (s_ack && ack_cnt != CNT_SAT) ack_cnt_nx = ack_cnt + 16'd1;
        if (release_bus) begin
          state_nx = IDLE;
          grant_nx = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      grant   <= '0;
      owner   <= LAST_IDX;
      ack_cnt <= '0;
    end else begin
      state   <= state_nx;
      grant   <= grant_nx;
      owner   <= owner_nx;
      ack_cnt <= ack_cnt_nx;
    end
  end

endmodule

`default_nettype wire

// File: doc/wshb_rr_arbiter.md
Name: wshb_rr_arbiter

Overview:
- Round-robin Wishbone arbiter that shares one SDRAM slave port among NB_MASTERS requesters, e.g. mire writer, VGA reader and future DMA.
- Grant is registered. A one-cycle idle gap is inserted between owners. Ownership is bounded by a burst-aware ack budget, so the VGA reader cannot starve when the mire streams continuously.
- Sits between the requester wshb_if buses (flattened) and the single SDRAM controller wshb_if.

Parameters:
- NB_MASTERS, 2, number of requesters; range 2..8
- ADR_W, 32, address width
- DATA_W, 16, data width; sel width is DATA_W/8
- MAX_ACKS, 64, ack budget per ownership before preemption is allowed; range 1..65535

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- m_cyc  in  NB_MASTERS  requester cyc, bit i = master i
- m_stb  in  NB_MASTERS  requester stb
- m_we  in  NB_MASTERS  requester we
- m_adr  in  NB_MASTERS*ADR_W  requester addresses, slice i = master i
- m_dat_ms  in  NB_MASTERS*DATA_W  requester write data
- m_sel  in  NB_MASTERS*DATA_W/8  requester byte selects
- m_cti  in  NB_MASTERS*3  requester cycle type
- m_bte  in  NB_MASTERS*2  requester burst type
- m_ack  out  NB_MASTERS  per-requester ack
- m_dat_sm  out  DATA_W  read data, broadcast to all requesters
- s_cyc, s_stb, s_we  out  1 each  to SDRAM controller
- s_adr  out  ADR_W
- s_dat_ms  out  DATA_W
- s_sel  out  DATA_W/8
- s_cti  out  3
- s_bte  out  2
- s_ack  in  1  from SDRAM controller
- s_dat_sm  in  DATA_W  from SDRAM controller
- grant  out  NB_MASTERS  one-hot current owner; all-zero when no owner

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n. All state updates on posedge clk.
- Reset (rst_n=0 at an edge):
  - state=IDLE, grant=0, ack_cnt=0.
  - last_owner=NB_MASTERS-1, so master 0 wins the first arbitration.
  - All s_* control outputs and m_ack are 0.
- Reset asserted mid-transfer: the bus is dropped at once. The requester sees no further ack and must reissue.
- State IDLE:
  - s_cyc=s_stb=0; s_adr, s_dat_ms, s_sel, s_cti, s_bte, s_we driven 0; m_ack=0.
  - If any m_cyc bit is set, select the first set bit scanning last_owner+1, last_owner+2, … modulo NB_MASTERS.
  - Load grant one-hot, last_owner=selected, ack_cnt=0, go to GRANT.
  - Latency: m_cyc high in cycle t with arbiter IDLE gives grant and s_cyc in cycle t+1.
- State GRANT:
  - s_* are combinationally muxed from the owner's slice.
  - m_ack[owner]=s_ack; other m_ack bits are 0.
  - m_dat_sm=s_dat_sm, always broadcast.
  - ack_cnt increments on each s_ack and saturates at MAX_ACKS.
- Release (GRANT to IDLE, grant cleared):
  - when m_cyc[owner]=0 at the clock edge; or
  - when ack_cnt has reached MAX_ACKS, another m_cyc bit is set, and s_ack is high this cycle with s_cti equal to 3'b000 or 3'b111. Preemption only happens at a classic or end-of-burst boundary, never mid incrementing burst.
- Preempted owner:
  - keeps cyc high, receives no ack while not granted, and is rescheduled in round-robin order.
  - Its counter restarts on the new grant.
- Gap between owners: every release produces at least one IDLE cycle with s_cyc=0.
- Back-to-back requests: a sole requester that drops cyc for one cycle and raises it again is re-granted after the IDLE cycle.
- No requesters: stays IDLE, grant=0.
- Stray acks:
  - s_ack while IDLE is ignored.
  - An owner that has dropped cyc receives no further acks; the state is already IDLE on the next cycle.

Optional Feature:
- Macro: WSHB_ARB_PRIO0_EN.
- Defined: master 0 (VGA) has absolute priority.
  - In IDLE, m_cyc[0] wins over any round-robin choice.
  - In GRANT with another owner, m_cyc[0]=1 forces release at the next boundary ack (s_ack with s_cti 3'b000 or 3'b111), regardless of ack_cnt.
  - Master 0 itself is never preempted by the budget.
- Not defined: pure round-robin as above; master 0 has no special treatment.

Test Plan:
- Reset then single requester: hold rst_n=0 for 2 cycles. Raise m_cyc[1] with addr 0x100 → grant=2'b10 and s_cyc=1 one cycle later, s_adr=0x100. m_ack[1] mirrors s_ack; m_ack[0]=0.
- Simultaneous first request: m_cyc=2'b11 right after reset → master 0 granted first. When it drops cyc, one IDLE cycle (s_cyc=0), then grant=2'b10.
- Budget preemption: MAX_ACKS=4, master 1 streams classic cycles, master 0 requests at ack 2 → release right after the 4th ack, one idle cycle, then grant=2'b01. Master 1 is regranted after master 0 drops cyc.
- Burst protection: MAX_ACKS=4, master 1 runs an 8-beat incrementing burst (cti 010 …, last 111) → no preemption until the 8th ack with cti=111.
- Reset mid-transfer: rst_n=0 during GRANT with s_ack pending → s_cyc=0, grant=0 and m_ack=0 at the next edge. Master 0 is granted first after release.
- WSHB_ARB_PRIO0_EN: master 1 owns the bus, m_cyc[0] rises at ack_cnt=1 with MAX_ACKS=64 → release on the next classic ack, grant=2'b01 after one idle cycle.
